seq_alu: RTL and testbench



---
 rtl/seq_alu_pkg.sv | 26 ++
 rtl/seq_alu_mul.sv | 63 ++++++
 rtl/seq_alu.sv | 192 +++++++++++++++++++
 tb/tb_seq_alu.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op codes and FSM state encoding shared by the sequential ALU.
// The multiplier op is only implemented when SEQ_ALU_MUL_EN is defined.
package seq_alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_NOT  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SEQ  = 4'd7;
   localparam logic [3:0] OP_SLTU = 4'd8;
   localparam logic [3:0] OP_SLL  = 4'd9;
   localparam logic [3:0] OP_SRL  = 4'd10;
   localparam logic [3:0] OP_SRA  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;
   localparam logic [3:0] OP_LAST = 4'd12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative unsigned shift-add multiplier, one multiplier bit
// per clock. A start pulse loads the operands; done pulses for one cycle once
// all WIDTH bits have been consumed, and product then holds the full result.
module seq_alu_mul #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;
   logic               done_q;

   // Load on start, then add the shifted multiplicand for each set multiplier bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
         end else if (busy_q) begin
            if (mplier_q[0]) begin
               acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = acc_q;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked integer execute unit. Single-cycle ops register their
// result straight into DONE; MUL (only when SEQ_ALU_MUL_EN is defined) runs
// the iterative multiplier in BUSY first. Without the macro, op 12 is illegal.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] da,
   input  logic [WIDTH-1:0] db,
   input  logic [3:0]       ALU_ctr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUout,
   output logic [WIDTH-1:0] mul_hi,
   output logic             less,
   output logic             zero,
   output logic             overflow,
   output logic             cout,
   output logic             illegal
);

   state_t           state_q;
   logic [WIDTH-1:0] aluOut_q;
   logic             outValid_q;
   logic             less_q, zero_q, ovf_q, cout_q, illegal_q;

   logic             accept;
   logic             subD;
   logic [WIDTH-1:0] bOpD;
   logic [WIDTH:0]   addD;
   logic [WIDTH-1:0] sumD;
   logic             carryD;
   logic             ovfRawD;
   logic [SHW-1:0]   shamtD;
   logic [WIDTH-1:0] resD;
   logic             lessD, zeroD, ovfD, coutD, illegalD;

   // A new op is taken whenever the producer offers one and we can accept it.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         DONE:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept = in_valid & in_ready;

   // Shared adder, its flags, and the single-cycle result mux.
   always_comb begin
      subD    = (ALU_ctr == OP_SUB) || (ALU_ctr == OP_SLT) ||
                (ALU_ctr == OP_SEQ) || (ALU_ctr == OP_SLTU);
      bOpD    = subD ? ~db : db;
      addD    = {1'b0, da} + {1'b0, bOpD} + {{WIDTH{1'b0}}, subD};
      sumD    = addD[WIDTH-1:0];
      carryD  = addD[WIDTH];
      ovfRawD = (da[WIDTH-1] == bOpD[WIDTH-1]) && (sumD[WIDTH-1] != da[WIDTH-1]);
      shamtD  = db[SHW-1:0];

      coutD    = carryD;
      zeroD    = (sumD == '0);
      ovfD     = ((ALU_ctr == OP_ADD) || (ALU_ctr == OP_SUB)) ? ovfRawD : 1'b0;
      lessD    = (ALU_ctr == OP_SLTU) ? ~carryD : (sumD[WIDTH-1] ^ ovfRawD);
      illegalD = 1'b0;
      resD     = '0;

      case (ALU_ctr)
         OP_ADD, OP_SUB: resD = sumD;
         OP_NOT:         resD = ~da;
         OP_AND:         resD = da & db;
         OP_OR:          resD = da | db;
         OP_XOR:         resD = da ^ db;
         OP_SLT, OP_SLTU: resD = {{(WIDTH-1){1'b0}}, lessD};
         OP_SEQ:         resD = {{(WIDTH-1){1'b0}}, zeroD};
         OP_SLL:         resD = da << shamtD;
         OP_SRL:         resD = da >> shamtD;
         OP_SRA:         resD = $signed(da) >>> shamtD;
         default: begin
            resD     = '0;
            illegalD = 1'b1;
            coutD    = 1'b0;
            zeroD    = 1'b0;
            ovfD     = 1'b0;
            lessD    = 1'b0;
         end
      endcase
   end

`ifdef SEQ_ALU_MUL_EN
   logic               mulStart;
   logic               mulBusy;
   logic               mulDone;
   logic [2*WIDTH-1:0] mulProduct;
   logic [WIDTH-1:0]   mulHi_q;

   assign mulStart = accept && (ALU_ctr == OP_MUL);

   seq_alu_mul #(.WIDTH(WIDTH)) uMul (
      .clk     (clk),
      .rst     (rst),
      .start   (mulStart),
      .a       (da),
      .b       (db),
      .busy    (mulBusy),
      .done    (mulDone),
      .product (mulProduct)
   );
`endif

   // Control FSM with registered result and flags held until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         outValid_q <= 1'b0;
         aluOut_q   <= '0;
         less_q     <= 1'b0;
         zero_q     <= 1'b0;
         ovf_q      <= 1'b0;
         cout_q     <= 1'b0;
         illegal_q  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         mulHi_q    <= '0;
`endif
      end else begin
`ifdef SEQ_ALU_MUL_EN
         if (mulStart) begin
            state_q    <= BUSY;
            outValid_q <= 1'b0;
         end else
`endif
         if (accept) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
            aluOut_q   <= resD;
            less_q     <= lessD;
            zero_q     <= zeroD;
            ovf_q      <= ovfD;
            cout_q     <= coutD;
            illegal_q  <= illegalD;
`ifdef SEQ_ALU_MUL_EN
            mulHi_q    <= '0;
`endif
         end else begin
            case (state_q)
`ifdef SEQ_ALU_MUL_EN
               BUSY: begin
                  if (mulDone && !mulBusy) begin
                     state_q    <= DONE;
                     outValid_q <= 1'b1;
                     aluOut_q   <= mulProduct[WIDTH-1:0];
                     mulHi_q    <= mulProduct[2*WIDTH-1:WIDTH];
                     ovf_q      <= |mulProduct[2*WIDTH-1:WIDTH];
                     less_q     <= 1'b0;
                     zero_q     <= 1'b0;
                     cout_q     <= 1'b0;
                     illegal_q  <= 1'b0;
                  end
               end
`endif
               DONE: begin
                  if (out_ready) begin
                     state_q    <= IDLE;
                     outValid_q <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign out_valid = outValid_q;
   assign ALUout    = aluOut_q;
   assign less      = less_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign cout      = cout_q;
   assign illegal   = illegal_q;
`ifdef SEQ_ALU_MUL_EN
   assign mul_hi    = mulHi_q;
`else
   assign mul_hi    = '0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors for seq_alu (WIDTH=8). Expected responses are
// queued when an op is issued and checked by a monitor on each handshake.
// MUL checks are used when SEQ_ALU_MUL_EN is defined, else op 12 is illegal.
module tb_seq_alu;
   import seq_alu_pkg::*;

   typedef struct packed {
      logic [7:0] res;
      logic [7:0] hi;
      logic       less;
      logic       zero;
      logic       ovf;
      logic       cout;
      logic       ill;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] da;
   logic [7:0] db;
   logic [3:0] ALU_ctr;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] ALUout;
   logic [7:0] mul_hi;
   logic       less, zero, overflow, cout, illegal;

   exp_t sb[$];
   int   testsRun;
   int   testsFailed;

   seq_alu #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .da        (da),
      .db        (db),
      .ALU_ctr   (ALU_ctr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUout    (ALUout),
      .mul_hi    (mul_hi),
      .less      (less),
      .zero      (zero),
      .overflow  (overflow),
      .cout      (cout),
      .illegal   (illegal)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(logic [7:0] r, logic [7:0] h, logic l, logic z,
                               logic o, logic c, logic i);
      exp_t e;
      e.res = r; e.hi = h; e.less = l; e.zero = z; e.ovf = o; e.cout = c; e.ill = i;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Offer one op, hold it until accepted, and queue its expected response.
   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a,
                                input logic [7:0] b, input exp_t e);
      logic acc;
      int   n;
      sb.push_back(e);
      ALU_ctr  = op;
      da       = a;
      db       = b;
      in_valid = 1'b1;
      acc      = 1'b0;
      n        = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      checkOutput("accept", {31'd0, acc}, 32'd1);
   endtask

   // Scoreboard monitor: every consumed result is matched against the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t got;
         exp_t want;
         got = {ALUout, mul_hi, less, zero, overflow, cout, illegal};
         testsRun++;
         if (sb.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL unexpected output: got res=0x%0h hi=0x%0h, expected none",
                     ALUout, mul_hi);
         end else begin
            want = sb.pop_front();
            if (got !== want) begin
               testsFailed++;
               $display("[TB] FAIL result: got res=0x%0h hi=0x%0h lzoci=%b, expected res=0x%0h hi=0x%0h lzoci=%b",
                        got.res, got.hi, {got.less, got.zero, got.ovf, got.cout, got.ill},
                        want.res, want.hi, {want.less, want.zero, want.ovf, want.cout, want.ill});
            end
         end
      end
   end

   task automatic checkCleared(input string tag);
      checkOutput({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
      checkOutput({tag, " ALUout"}, {24'd0, ALUout}, 32'd0);
      checkOutput({tag, " mul_hi"}, {24'd0, mul_hi}, 32'd0);
      checkOutput({tag, " flags"}, {27'd0, less, zero, overflow, cout, illegal}, 32'd0);
      checkOutput({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int cnt;
      testsRun    = 0;
      testsFailed = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      da        = '0;
      db        = '0;
      ALU_ctr   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkCleared("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // First op with explicit one-cycle latency check.
      applyStimulus(OP_ADD, 8'h7F, 8'h01, mk(8'h80, 8'h00, 0, 0, 1, 0, 0));
      @(negedge clk);
      checkOutput("add latency", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;

      applyStimulus(OP_SUB,  8'h05, 8'h05, mk(8'h00, 8'h00, 0, 1, 0, 1, 0));
      applyStimulus(OP_SLTU, 8'h03, 8'hF0, mk(8'h01, 8'h00, 1, 0, 0, 0, 0));
      applyStimulus(OP_SLT,  8'h03, 8'hF0, mk(8'h00, 8'h00, 0, 0, 0, 0, 0));
      applyStimulus(OP_SRA,  8'h80, 8'h0B, mk(8'hF0, 8'h00, 1, 0, 0, 0, 0));
      applyStimulus(OP_SLL,  8'h01, 8'h07, mk(8'h80, 8'h00, 0, 0, 0, 0, 0));
      applyStimulus(OP_SRL,  8'hF0, 8'h04, mk(8'h0F, 8'h00, 1, 0, 0, 0, 0));
      applyStimulus(OP_SEQ,  8'h33, 8'h33, mk(8'h01, 8'h00, 0, 1, 0, 1, 0));
      applyStimulus(OP_XOR,  8'hA5, 8'h0F, mk(8'hAA, 8'h00, 1, 0, 0, 0, 0));
      applyStimulus(OP_AND,  8'hF0, 8'h3C, mk(8'h30, 8'h00, 0, 0, 0, 1, 0));
      applyStimulus(OP_NOT,  8'h0F, 8'h00, mk(8'hF0, 8'h00, 0, 0, 0, 0, 0));
      applyStimulus(OP_ADD,  8'hFF, 8'h01, mk(8'h00, 8'h00, 0, 1, 0, 1, 0));
      applyStimulus(4'd13,   8'h05, 8'h05, mk(8'h00, 8'h00, 0, 0, 0, 0, 1));
      applyStimulus(4'd15,   8'hFF, 8'hFF, mk(8'h00, 8'h00, 0, 0, 0, 0, 1));

`ifdef SEQ_ALU_MUL_EN
      // Multiply: in_ready low and no result for the whole iterative phase.
      applyStimulus(OP_MUL, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 0, 0, 1, 0, 0));
      cnt = 0;
      do begin
         @(negedge clk);
         if (!out_valid) begin
            checkOutput("busy in_ready", {31'd0, in_ready}, 32'd0);
            cnt++;
         end
      end while (!out_valid && cnt < 50);
      checkOutput("mul latency", cnt, 32'd9);
      @(posedge clk);
      #1;
`else
      applyStimulus(OP_MUL, 8'hFF, 8'hFF, mk(8'h00, 8'h00, 0, 0, 0, 0, 1));
`endif
      repeat (2) @(posedge clk);
      #1;

      // Result held while the consumer stalls, then back-to-back accept.
      out_ready = 1'b0;
      applyStimulus(OP_OR, 8'h0C, 8'h03, mk(8'h0F, 8'h00, 0, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold valid", {31'd0, out_valid}, 32'd1);
         checkOutput("hold data", {24'd0, ALUout}, 32'h0F);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      applyStimulus(OP_ADD, 8'h01, 8'h01, mk(8'h02, 8'h00, 0, 0, 0, 0, 0));
      @(negedge clk);
      checkOutput("b2b valid", {31'd0, out_valid}, 32'd1);
      checkOutput("b2b data", {24'd0, ALUout}, 32'h02);
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of an outstanding op discards it completely.
`ifdef SEQ_ALU_MUL_EN
      applyStimulus(OP_MUL, 8'h12, 8'h34, mk(8'h00, 8'h00, 0, 0, 0, 0, 0));
      repeat (3) @(posedge clk);
      #1;
`else
      out_ready = 1'b0;
      applyStimulus(OP_ADD, 8'h10, 8'h20, mk(8'h30, 8'h00, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
`endif
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkCleared("midop reset");
      @(posedge clk);
      #1;

      // Let any remaining expectations drain before summarising.
      cnt = 0;
      while (sb.size() != 0 && cnt < 100) begin
         @(posedge clk);
         cnt++;
      end
      checkOutput("drain", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
